// File: rtl/grostl_nonce_scanner.sv
// grostl_nonce_scanner
// Issues one nonce per clock to a fully pipelined grostl512 core across an
// inclusive range, compares each returned hash against a 64-bit target and
// queues winning nonces in a small FIFO behind a valid/ready pop interface.
// Build option: define GROSTL_SCAN_STOP_ON_HIT_EN to stop issuing nonces at
// the first registered hit (nonces already in flight are still checked).
module grostl_nonce_scanner #(
  parameter int unsigned LATENCY    = 58,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  start_nonce,
  input  logic [31:0]  end_nonce,
  input  logic [63:0]  target,
  output logic [31:0]  nonce,
  input  logic [511:0] hash,
  output logic         busy,
  output logic         done,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  input  logic         found_ready,
  output logic         overflow
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned TGT_W   = 64;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_n;

  logic                 busy_d;
  logic                 done_d;
  logic                 load_range;
  logic                 inc_nonce;
  logic                 shift_in;
  logic                 clear_fifo;

  logic                 range_ok;
  logic                 at_end;
  logic                 stop_hit;
  logic                 vsr_empty;

  logic [NONCE_W-1:0]   end_q;
  logic [TGT_W-1:0]     target_q;
  logic [LATENCY-1:0]   vsr;

  logic [NONCE_W-1:0]   chk_nonce;
  logic [NONCE_W-1:0]   hit_nonce;
  logic                 hit_v;
  logic                 hit_q;
  logic                 push;

  logic [NONCE_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_n;
  logic [PTR_W-1:0]     wr_n;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 drop;
  logic [NONCE_W-1:0]   head_n;

  // Only the top 64 bits of the digest take part in the target compare.
  logic                 unused_hash_low;
  assign unused_hash_low = ^hash[447:0];

  assign range_ok  = start_nonce <= end_nonce;
  assign at_end    = nonce == end_q;
  assign vsr_empty = ~|vsr;
  assign push      = hit_v & hit_q;

`ifdef GROSTL_SCAN_STOP_ON_HIT_EN
  assign stop_hit = push;
`else
  assign stop_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // FSM next-state logic; DRAIN ends once the last valid slot has left vsr,
  // its compare result retires into the FIFO on the same edge FIN is entered.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = range_ok ? RUN : FIN;
        end
      end
      RUN: begin
        if (at_end || stop_hit) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (vsr_empty) begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM outputs: datapath controls and next values of busy/done
  always_comb begin
    load_range = 1'b0;
    inc_nonce  = 1'b0;
    shift_in   = 1'b0;
    clear_fifo = 1'b0;
    busy_d     = busy;
    done_d     = state_n == FIN;
    case (state_q)
      IDLE: begin
        clear_fifo = start;
        load_range = start & range_ok;
        busy_d     = start & range_ok;
      end
      RUN: begin
        shift_in  = 1'b1;
        inc_nonce = state_n == RUN;
      end
      FIN: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = busy;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Issue side: nonce counter and scan parameters captured on start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nonce    <= '0;
      end_q    <= '0;
      target_q <= '0;
    end else if (load_range) begin
      nonce    <= start_nonce;
      end_q    <= end_nonce;
      target_q <= target;
    end else if (inc_nonce) begin
      nonce <= nonce + NONCE_W'(1);
    end
  end

  // Valid shift register tracking which core outputs belong to issued nonces
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsr <= '0;
    end else begin
      vsr <= {vsr[LATENCY-2:0], shift_in};
    end
  end

  // Compare stage: register hit flag with the nonce that produced the hash
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_nonce <= '0;
      hit_nonce <= '0;
      hit_v     <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      hit_v <= vsr[LATENCY-1];
      hit_q <= vsr[LATENCY-1] & (hash[511:448] <= target_q);
      if (load_range) begin
        chk_nonce <= start_nonce;
      end else if (vsr[LATENCY-1]) begin
        chk_nonce <= chk_nonce + NONCE_W'(1);
        hit_nonce <= chk_nonce;
      end
    end
  end

  // FIFO next-state: a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    pop_ok  = found_valid & found_ready;
    push_ok = push & ((cnt != CNT_W'(FIFO_DEPTH)) | pop_ok);
    drop    = push & ~push_ok;
    rd_n    = rd_ptr + PTR_W'(pop_ok);
    wr_n    = wr_ptr + PTR_W'(push_ok);
    cnt_n   = cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_n  = '0;
    if (cnt_n != '0) begin
      if (push_ok && (cnt == CNT_W'(pop_ok))) begin
        head_n = hit_nonce;
      end else begin
        head_n = mem[rd_n];
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok && !clear_fifo) begin
      mem[wr_ptr] <= hit_nonce;
    end
  end

  // FIFO pointers, registered head/valid and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      overflow    <= 1'b0;
    end else if (clear_fifo) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      overflow    <= 1'b0;
    end else begin
      rd_ptr      <= rd_n;
      wr_ptr      <= wr_n;
      cnt         <= cnt_n;
      found_valid <= cnt_n != '0;
      found_nonce <= head_n;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
